// File: rtl/wb_fifo_drain.sv
// wb_fifo_drain: Wishbone master that empties a single-entry mailbox
// slave and forwards each drained word on a valid/ready stream.
module wb_fifo_drain #(
  parameter int            AW            = 32,
  parameter int            DW            = 32,
  parameter logic [AW-1:0] BASE_ADR      = '0,
  parameter bit            USE_IRQ       = 1'b0,
  parameter int            POLL_INTERVAL = 16,
  parameter int            TIMEOUT       = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable_i,
  input  logic            irq_i,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic [2:0]      wbm_cti_o,
  output logic [1:0]      wbm_bte_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  input  logic            wbm_rty_i,
  output logic [DW-1:0]   m_data_o,
  output logic            m_valid_o,
  input  logic            m_ready_i,
  output logic            err_o,
  input  logic            err_clr_i
);

  localparam int GW = $clog2(POLL_INTERVAL + 1);
  localparam logic [AW-1:0] STAT_ADR = BASE_ADR + AW'(DW / 8);
  localparam logic [GW-1:0] GAP_LD = GW'(POLL_INTERVAL);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    STAT,
    DATA,
    GAP,
    PUSH
  } state_t;

  state_t        state;
  logic [GW-1:0] gcnt;
  logic [7:0]    wcnt;
  logic          tmo;

  assign tmo = (wcnt == TO_LAST);

  assign wbm_dat_o = '0;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = 1'b0;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;
  assign wbm_stb_o = wbm_cyc_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gcnt      <= '0;
      wcnt      <= '0;
      wbm_adr_o <= '0;
      wbm_cyc_o <= 1'b0;
      m_data_o  <= '0;
      m_valid_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      // a fresh error later in this block overrides the clear
      if (err_clr_i) err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable_i) begin
            if (!USE_IRQ) begin
              state     <= STAT;
              wbm_cyc_o <= 1'b1;
              wbm_adr_o <= STAT_ADR;
              wcnt      <= '0;
            end else if (irq_i) begin
              state     <= DATA;
              wbm_cyc_o <= 1'b1;
              wbm_adr_o <= BASE_ADR;
              wcnt      <= '0;
            end
          end
        end
        STAT, DATA: begin
          if (!wbm_cyc_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_adr_o <= (state == STAT) ? STAT_ADR : BASE_ADR;
            wcnt      <= '0;
          end else if (wbm_err_i) begin
            wbm_cyc_o <= 1'b0;
            err_o     <= 1'b1;
            state     <= GAP;
            gcnt      <= GAP_LD;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            if (state == DATA) begin
              m_data_o  <= wbm_dat_i;
              m_valid_o <= 1'b1;
              state     <= PUSH;
            end else if (wbm_dat_i[1]) begin
              state <= DATA;
            end else begin
              state <= GAP;
              gcnt  <= GAP_LD;
            end
          end else if (wbm_rty_i) begin
            wbm_cyc_o <= 1'b0;
            state     <= GAP;
            gcnt      <= GAP_LD;
          end else if (tmo) begin
            wbm_cyc_o <= 1'b0;
            err_o     <= 1'b1;
            state     <= GAP;
            gcnt      <= GAP_LD;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        GAP: begin
          if (gcnt <= GW'(1)) state <= IDLE;
          else gcnt <= gcnt - GW'(1);
        end
        PUSH: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
